// File: rtl/mem_arbiter.sv
// Three-requester round-robin arbiter for a single shared memory port.
// Define ARB_TIMEOUT_EN to build the hold counter that bounds a contended grant to MAX_HOLD cycles.

module mem_arbiter_lane #(
  parameter int W = 16
) (
  input  logic         gnt,
  input  logic [W-1:0] addr,
  input  logic [W-1:0] wdata,
  input  logic         wr_en,
  output logic [W-1:0] addr_g,
  output logic [W-1:0] wdata_g,
  output logic         wr_en_g
);
  // AND-gating per lane: an ungranted lane contributes all zeros to the OR mux.
  assign addr_g  = gnt ? addr  : '0;
  assign wdata_g = gnt ? wdata : '0;
  assign wr_en_g = gnt & wr_en;
endmodule

module mem_arbiter #(
  parameter int WORD_WIDTH = 16,
  parameter int MAX_HOLD   = 16
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic [2:0]            req,
  input  logic [WORD_WIDTH-1:0] addr0,
  input  logic [WORD_WIDTH-1:0] addr1,
  input  logic [WORD_WIDTH-1:0] addr2,
  input  logic                  wr_en0,
  input  logic                  wr_en1,
  input  logic                  wr_en2,
  input  logic [WORD_WIDTH-1:0] wdata0,
  input  logic [WORD_WIDTH-1:0] wdata1,
  input  logic [WORD_WIDTH-1:0] wdata2,
  output logic [2:0]            gnt,
  output logic [1:0]            owner_id,
  output logic [WORD_WIDTH-1:0] mem_address,
  output logic                  mem_wr_en,
  output logic [WORD_WIDTH-1:0] mem_data_in,
  input  logic [WORD_WIDTH-1:0] mem_data_out,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  busy
);
  localparam int NUM_REQ = 3;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [2:0] gnt_q, gnt_d;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
`endif

  logic [NUM_REQ-1:0][WORD_WIDTH-1:0] addr_a, wdata_a, addr_g, wdata_g;
  logic [NUM_REQ-1:0]                 wr_en_a, wr_en_g;

  assign addr_a  = {addr2, addr1, addr0};
  assign wdata_a = {wdata2, wdata1, wdata0};
  assign wr_en_a = {wr_en2, wr_en1, wr_en0};

  // First requester after 'last' in the order last+1, last+2, last+3 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(last) + k) % NUM_REQ);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    logic [1:0] win;
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    win     = rr_pick(req, owner_q);
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          win     = rr_pick(req, last_q);
          state_d = OWNED;
          owner_d = win;
          gnt_d   = 3'b001 << win;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      OWNED: begin
        if (!req[owner_q]) begin
          // Hand over in the same edge so the memory port never idles between owners.
          last_d = owner_q;
          if (|req) begin
            owner_d = win;
            gnt_d   = 3'b001 << win;
`ifdef ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST && |(req & ~gnt_q)) begin
          // Preempted owner keeps its req and simply re-enters the rotation.
          last_d  = owner_q;
          owner_d = win;
          gnt_d   = 3'b001 << win;
          hold_d  = '0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      gnt_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    mem_arbiter_lane #(.W(WORD_WIDTH)) u_lane (
      .gnt    (gnt_q[i]),
      .addr   (addr_a[i]),
      .wdata  (wdata_a[i]),
      .wr_en  (wr_en_a[i]),
      .addr_g (addr_g[i]),
      .wdata_g(wdata_g[i]),
      .wr_en_g(wr_en_g[i])
    );
  end

  always_comb begin
    mem_address = '0;
    mem_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mem_address = mem_address | addr_g[i];
      mem_data_in = mem_data_in | wdata_g[i];
    end
  end

  assign mem_wr_en = |wr_en_g;
  assign gnt       = gnt_q;
  assign busy      = |gnt_q;
  assign owner_id  = (state_q == OWNED) ? owner_q : 2'd3;
  assign rd_data   = mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, grant latency, round-robin handover, write gating,
// mid-grant reset, and either indefinite hold or timeout preemption depending on ARB_TIMEOUT_EN.
module tb_mem_arbiter;
`ifdef ARB_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif

  logic        clock = 1'b0;
  logic        nreset;
  logic [2:0]  req;
  logic [15:0] addr0, addr1, addr2, wdata0, wdata1, wdata2;
  logic        wr_en0, wr_en1, wr_en2;
  logic [2:0]  gnt;
  logic [1:0]  owner_id;
  logic [15:0] mem_address, mem_data_in, mem_data_out, rd_data;
  logic        mem_wr_en, busy;

  int pass_cnt = 0;
  int total    = 0;
  int order[4] = '{0, 1, 2, 0};

  mem_arbiter #(.WORD_WIDTH(16), .MAX_HOLD(MH)) dut (
    .clock(clock), .nreset(nreset), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wr_en0(wr_en0), .wr_en1(wr_en1), .wr_en2(wr_en2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(gnt), .owner_id(owner_id),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .rd_data(rd_data), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_gnt(input string tag, input logic [2:0] g);
    logic [1:0] oid;
    case (g)
      3'b001:  oid = 2'd0;
      3'b010:  oid = 2'd1;
      3'b100:  oid = 2'd2;
      default: oid = 2'd3;
    endcase
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".owner_id"}, 32'(owner_id), 32'(oid));
    chk({tag, ".busy"}, 32'(busy), 32'(g != 3'b000));
  endtask

  initial begin
    nreset = 1'b0; req = 3'b000;
    addr0 = 16'h01C8; addr1 = 16'h0222; addr2 = 16'h03F0;
    wdata0 = 16'hAAAA; wdata1 = 16'h5555; wdata2 = 16'h0F0F;
    wr_en0 = 1'b0; wr_en1 = 1'b0; wr_en2 = 1'b0;
    mem_data_out = 16'hBEEF;
    step(); step();

    check_gnt("reset", 3'b000);
    chk("reset.mem_address", 32'(mem_address), 'h0);
    chk("reset.mem_data_in", 32'(mem_data_in), 'h0);
    chk("reset.mem_wr_en", 32'(mem_wr_en), 'h0);
    chk("rd_data", 32'(rd_data), 'hBEEF);

    nreset = 1'b1; step();
    check_gnt("idle_no_req", 3'b000);

    req = 3'b001; step();
    check_gnt("first_grant", 3'b001);
    chk("first_grant.mem_address", 32'(mem_address), 'h1C8);
    chk("first_grant.mem_data_in", 32'(mem_data_in), 'hAAAA);

    wr_en1 = 1'b1; #1;
    chk("wr_gate.mem_wr_en", 32'(mem_wr_en), 'h0);
    chk("wr_gate.mem_address", 32'(mem_address), 'h1C8);
    wr_en0 = 1'b1; #1;
    chk("owner_wr.mem_wr_en", 32'(mem_wr_en), 'h1);
    wr_en0 = 1'b0; wr_en1 = 1'b0;

    // Round-robin: each owner holds 3 cycles then drops req for one.
    nreset = 1'b0; req = 3'b000; step();
    nreset = 1'b1; req = 3'b111; step();
    check_gnt("rr_start", 3'b001);
    for (int i = 0; i < 3; i++) begin
      step(); check_gnt("rr_hold_a", 3'(1 << order[i]));
      step(); check_gnt("rr_hold_b", 3'(1 << order[i]));
      req = 3'b111 & ~3'(1 << order[i]);
      step(); check_gnt("rr_handover", 3'(1 << order[i+1]));
      req = 3'b111;
    end

    req = 3'b100; wr_en2 = 1'b1; step();
    check_gnt("owner2", 3'b100);
    chk("owner2.mem_wr_en", 32'(mem_wr_en), 'h1);
    chk("owner2.mem_address", 32'(mem_address), 'h3F0);
    chk("owner2.mem_data_in", 32'(mem_data_in), 'h0F0F);
    nreset = 1'b0; step();
    check_gnt("midreset", 3'b000);
    chk("midreset.mem_wr_en", 32'(mem_wr_en), 'h0);
    nreset = 1'b1; step();
    check_gnt("post_reset", 3'b100);
    wr_en2 = 1'b0;

`ifndef ARB_TIMEOUT_EN
    req = 3'b111;
    for (int i = 0; i < 12; i++) begin
      step(); check_gnt("hold_forever", 3'b100);
    end
    req = 3'b011; step();
    check_gnt("wrap_2_to_0", 3'b001);
`else
    nreset = 1'b0; req = 3'b000; step();
    nreset = 1'b1; req = 3'b001; step();
    check_gnt("to_start", 3'b001);
    req = 3'b011;
    step(); check_gnt("to_hold1", 3'b001);
    step(); check_gnt("to_hold2", 3'b001);
    step(); check_gnt("to_hold3", 3'b001);
    step(); check_gnt("to_preempt", 3'b010);
    req = 3'b001; step();
    check_gnt("to_recompete", 3'b001);

    nreset = 1'b0; req = 3'b000; step();
    nreset = 1'b1; req = 3'b001;
    for (int i = 0; i < 10; i++) begin
      step(); check_gnt("to_saturate", 3'b001);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take parameter WORD_WIDTH, default 16, as the width of memory address and data words.
REQ-002 The block SHALL take parameter MAX_HOLD, default 16, as the maximum consecutive grant cycles when ARB_TIMEOUT_EN is defined.
REQ-003 Port clock  input  1: sole clock; all state updates on its rising edge.
REQ-004 Port nreset  input  1: synchronous, active-low reset.
REQ-005 Port req  input  3: request per requester; bit 0 = reward unit, bit 1 = Q-update unit, bit 2 = packet handler.
REQ-006 Ports addr0/addr1/addr2  input  WORD_WIDTH each: requester memory address.
REQ-007 Ports wr_en0/wr_en1/wr_en2  input  1 each: requester write enable.
REQ-008 Ports wdata0/wdata1/wdata2  input  WORD_WIDTH each: requester write data.
REQ-009 Port gnt  output  3: registered one-hot grant; at most one bit high.
REQ-010 Port owner_id  output  2: index of granted requester; 3 when idle.
REQ-011 Ports mem_address  output  WORD_WIDTH, mem_wr_en  output  1, mem_data_in  output  WORD_WIDTH: drive the shared memory.
REQ-012 Port mem_data_out  input  WORD_WIDTH: shared memory read data.
REQ-013 Port rd_data  output  WORD_WIDTH: mem_data_out passed through to all requesters.
REQ-014 Port busy  output  1: high whenever any gnt bit is high.

Function
REQ-015 The block SHALL implement two states: IDLE (no grant) and OWNED (one grant held).
REQ-016 From IDLE, the block SHALL enter OWNED and assert the winner's gnt at the first edge sampling any req bit high, i.e. one-cycle grant latency.
REQ-017 Arbitration SHALL be round-robin: search starts at the index after last_owner, wrapping 2->0.
REQ-018 In OWNED, the grant SHALL persist while the owner's req stays high, regardless of other requests (ARB_TIMEOUT_EN undefined).
REQ-019 At the edge sampling the owner's req low, the block SHALL set last_owner to the owner and, in the same edge, grant the next round-robin requester if any req is high, else return to IDLE; there SHALL be no idle bubble.
REQ-020 mem_address, mem_wr_en and mem_data_in SHALL be a combinational mux of the owner's addr, wr_en and wdata.
REQ-021 When no grant is held, mem_wr_en SHALL be 0 and mem_address/mem_data_in SHALL be 0.
REQ-022 A requester's wr_en SHALL never reach memory unless its gnt bit is high.
REQ-023 A req deasserted and reasserted by a non-owner before being granted SHALL be treated as continuously requesting.
REQ-024 owner_id and busy SHALL be consistent with gnt in every cycle.

Reset
REQ-025 While nreset is low at a rising edge: gnt=0, owner_id=3, busy=0, last_owner=2 (so requester 0 has first priority), hold counter=0, state=IDLE.
REQ-026 Reset asserted mid-grant SHALL drop the grant at that edge; mem_wr_en SHALL be 0 from the following cycle until a new grant.

Configuration
REQ-027 With ARB_TIMEOUT_EN defined, an 8-bit hold counter SHALL clear on each new grant and increment each OWNED cycle.
REQ-028 With ARB_TIMEOUT_EN defined, when the counter equals MAX_HOLD-1 and another req bit is high, the grant SHALL move to the next round-robin requester at that edge; the preempted requester re-competes with req still high.
REQ-029 With ARB_TIMEOUT_EN defined and no other requester pending, the counter SHALL saturate at MAX_HOLD-1 and the grant SHALL be kept.
REQ-030 Without ARB_TIMEOUT_EN, the counter logic SHALL not be built and grants SHALL be held indefinitely.

Verification
REQ-031 Reset then req=3'b001 -> gnt=3'b001 one edge later; mem_address follows addr0=0x1C8; owner_id=0; busy=1.
REQ-032 req=3'b111 held; each owner drops req for one cycle after 3 cycles -> grant order 0,1,2,0 with no idle cycle between owners.
REQ-033 wr_en1=1 with req1 low while owner=0 -> mem_wr_en stays wr_en0 value; no write to addr1.
REQ-034 nreset low while owner=2 with wr_en2=1 -> gnt=0, owner_id=3, mem_wr_en=0 from the next cycle; after release, req=3'b100 -> gnt=3'b100.
REQ-035 ARB_TIMEOUT_EN, MAX_HOLD=4, req0 held and req1 raised during cycle 1 of grant -> gnt moves 001->010 after 4 owned cycles.
REQ-036 ARB_TIMEOUT_EN, MAX_HOLD=4, req0 alone for 10 cycles -> gnt=001 throughout.
